// File: rtl/alu_mc_pkg.sv
// Shared definitions for the multi-cycle ALU:
// op codes, FSM states and the WIDTH legality check.
package alu_mc_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_ROL = 4'b0100;
    localparam logic [3:0] OP_SLL = 4'b0101;
    localparam logic [3:0] OP_SRA = 4'b0110;
    localparam logic [3:0] OP_SRL = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_DIV = 4'b1001;

    function automatic bit width_ok(input int w);
        return (w == 8) || (w == 16) || (w == 32);
    endfunction

endpackage

// File: rtl/alu_mc_shifter.sv
// Combinational shifter: rotate left, shift left,
// arithmetic and logical shift right.
module shifter_p #(
    parameter int WIDTH = 16
) (
    input  logic [1:0]               i_mode,
    input  logic [WIDTH-1:0]         i_a,
    input  logic [$clog2(WIDTH)-1:0] i_cnt,
    output logic [WIDTH-1:0]         o_y
);

    logic [WIDTH-1:0] w_rol;

    assign w_rol = WIDTH'(({i_a, i_a} << i_cnt) >> WIDTH);

    always_comb begin
        o_y = i_a;
        unique case (i_mode)
            2'b00: o_y = w_rol;
            2'b01: o_y = i_a << i_cnt;
            2'b10: o_y = $signed(i_a) >>> i_cnt;
            2'b11: o_y = i_a >> i_cnt;
            default: o_y = i_a;
        endcase
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle add/logic/shift, iterative
// shift-add multiply and restoring divide on one shared adder.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic [3:0]       Op,
    input  logic             invA,
    input  logic             invB,
    input  logic             clearB,
    input  logic             sign,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] Out,
    output logic             Ofl,
    output logic             Z
);

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("alu_mc: WIDTH must be 8, 16 or 32");
    end

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_m;
    logic [WIDTH-1:0]   r_out;
    logic               r_ofl;
    logic               r_z;

    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;
    logic [WIDTH-1:0]   w_shf;
    logic [WIDTH:0]     w_x;
    logic [WIDTH:0]     w_y;
    logic               w_c;
    logic [WIDTH+1:0]   w_sum;
    logic [2*WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_res;
    logic               w_ofl;
    logic               w_last;
    logic               w_ge;
    logic               w_busy;
    logic               w_valid;

    assign w_a = invA ? ~A : A;
    assign w_b = clearB ? '0 : (invB ? ~B : B);
    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    shifter_p #(.WIDTH(WIDTH)) u_shf (
        .i_mode (Op[1:0]),
        .i_a    (w_a),
        .i_cnt  (w_b[CNT_W-1:0]),
        .o_y    (w_shf)
    );

    // DIV trial subtract: shifted remainder + ~divisor + 1
    always_comb begin
        w_x = {1'b0, w_a};
        w_y = {1'b0, w_b};
        w_c = Cin;
        unique case (r_state)
            S_MUL: begin
                w_x = {1'b0, r_acc[2*WIDTH-1:WIDTH]};
                w_y = {1'b0, r_m};
                w_c = 1'b0;
            end
            S_DIV: begin
                w_x = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
                w_y = ~{1'b0, r_m};
                w_c = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_sum = {1'b0, w_x} + {1'b0, w_y}
                 + {{(WIDTH+1){1'b0}}, w_c};
    assign w_ge  = w_sum[WIDTH+1];

    always_comb begin
        w_rem     = w_ge ? w_sum[WIDTH-1:0]
                         : {r_acc[2*WIDTH-2:WIDTH], r_acc[WIDTH-1]};
        w_acc_nxt = {1'b0, r_acc[2*WIDTH-1:1]};
        if (r_state == S_DIV)
            w_acc_nxt = {w_rem, r_acc[WIDTH-2:0], w_ge};
        else if (r_acc[0])
            w_acc_nxt = {w_sum[WIDTH:0], r_acc[WIDTH-1:1]};
    end

    always_comb begin
        w_res = '0;
        w_ofl = 1'b0;
        unique case (1'b1)
            Op[3]: ;
            (~Op[3] & Op[2]): w_res = w_shf;
            (~Op[3] & ~Op[2]): begin
                unique case (Op[1:0])
                    2'b00: begin
                        w_res = w_sum[WIDTH-1:0];
                        w_ofl = sign
                            ? ((w_a[WIDTH-1] == w_b[WIDTH-1])
                              && (w_sum[WIDTH-1] != w_a[WIDTH-1]))
                            : w_sum[WIDTH];
                    end
                    2'b01: w_res = w_a | w_b;
                    2'b10: w_res = w_a ^ w_b;
                    2'b11: w_res = w_a & w_b;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b1;
        w_valid     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (start) begin
                    if (Op == OP_MUL)      w_state_nxt = S_MUL;
                    else if (Op == OP_DIV) w_state_nxt = S_DIV;
                    else                   w_state_nxt = S_DONE;
                end
            end
            S_MUL, S_DIV: begin
                if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_valid     = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_m     <= '0;
            r_out   <= '0;
            r_ofl   <= 1'b0;
            r_z     <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && start) begin
                r_cnt <= '0;
                if (Op == OP_MUL) begin
                    r_m   <= w_a;
                    r_acc <= {{WIDTH{1'b0}}, w_b};
                end else if (Op == OP_DIV) begin
                    r_m   <= w_b;
                    r_acc <= {{WIDTH{1'b0}}, w_a};
                end else begin
                    r_out <= w_res;
                    r_ofl <= w_ofl;
                    r_z   <= (w_res == '0);
                end
            end else if (r_state == S_MUL || r_state == S_DIV) begin
                r_acc <= w_acc_nxt;
                r_cnt <= r_cnt + 1'b1;
                if (w_last) begin
                    r_cnt <= '0;
                    r_out <= w_acc_nxt[WIDTH-1:0];
                    r_ofl <= (r_state == S_MUL)
                           ? |w_acc_nxt[2*WIDTH-1:WIDTH]
                           : ~|r_m;
                    r_z   <= (w_acc_nxt[WIDTH-1:0] == '0);
                end
            end
        end
    end

    assign busy  = w_busy;
    assign valid = w_valid;
    assign Out   = r_out;
    assign Ofl   = r_ofl;
    assign Z     = r_z;

endmodule
